// File: rtl/trace_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trace_packetizer                                              |
// | Purpose  : captures per-cycle commit records into a FIFO and streams     |
// |            them as 9/13/17-byte big-endian packets on a valid/ready port |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module trace_packetizer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_en,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instr_in,
  input  logic [31:0]   alu_result_in,
  input  logic [31:0]   write_data_in,
  input  logic          mem_write_in,
  input  logic          reg_write_in,
  input  logic [3:0]    flags_in,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_last,
  output logic [7:0]    drop_count,
  output logic [AW:0]   fifo_level,
  output logic          busy
);

  localparam int          c_PKT_W = 136;
  localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_PKT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_drop_pending;
  logic [c_PKT_W-1:0] r_pkt;
  logic [4:0]         r_idx;

  logic [c_PKT_W-1:0] w_head;
  logic [c_PKT_W-1:0] w_new_pkt;
  logic               w_accept;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [4:0]         w_last_idx;
  logic [4:0]         w_next_idx;

  // Records are stored already laid out as wire bytes: header, pc, instr, alu, wdata.
  assign w_new_pkt = {1'b1, r_drop_pending, mem_write_in, reg_write_in, flags_in,
                      pc_in, instr_in, alu_result_in, write_data_in};
  assign w_head    = r_mem[r_rd_ptr];

  assign w_accept   = tx_valid & tx_ready;
  assign w_pop      = (r_count != '0) & ((r_state == S_IDLE) | (w_accept & tx_last));
  assign w_push     = cap_en & ((r_count != c_DEPTH) | w_pop);
  assign w_drop     = cap_en & ~w_push;
  assign w_last_idx = r_pkt[133] ? 5'd16 : (r_pkt[132] ? 5'd12 : 5'd8);
  assign w_next_idx = r_idx + 5'd1;

  assign tx_valid   = (r_state == S_SEND);
  assign busy       = (r_state == S_SEND);
  assign fifo_level = r_count;

  function automatic logic [7:0] pkt_byte(input logic [c_PKT_W-1:0] pkt,
                                          input logic [4:0]         idx);
    logic [c_PKT_W-1:0] w_sh;
    w_sh = pkt << {idx, 3'b000};
    return w_sh[c_PKT_W-1 -: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= w_new_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_drop_pending <= 1'b0;
      drop_count     <= 8'h00;
      r_pkt          <= '0;
      r_idx          <= 5'd0;
      tx_data        <= 8'h00;
      tx_last        <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      // A drop and an accepted push are mutually exclusive within one cycle.
      if (w_drop) begin
        r_drop_pending <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
      end else if (w_push) begin
        r_drop_pending <= 1'b0;
      end

      if (w_pop) begin
        r_pkt   <= w_head;
        r_idx   <= 5'd0;
        tx_data <= w_head[c_PKT_W-1 -: 8];
        tx_last <= 1'b0;
        r_state <= S_SEND;
      end else if (w_accept) begin
        if (tx_last) begin
          tx_last <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_idx   <= w_next_idx;
          tx_data <= pkt_byte(r_pkt, w_next_idx);
          tx_last <= (w_next_idx == w_last_idx);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trace_packetizer                                           |
// | Purpose  : randomized and directed bench with a queue-based trace model  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_trace_packetizer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cap_en;
  logic [31:0] pc_in, instr_in, alu_result_in, write_data_in;
  logic        mem_write_in, reg_write_in;
  logic [3:0]  flags_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [7:0]  drop_count;
  logic [AW:0] fifo_level;
  logic        busy;

  trace_packetizer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cap_en(cap_en),
    .pc_in(pc_in), .instr_in(instr_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .flags_in(flags_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .drop_count(drop_count), .fifo_level(fifo_level),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw, rw, drop;
    logic [3:0]  fl;
    logic [31:0] pc, ins, alu, wd;
  } rec_t;

  // Reference model: pending records, bytes of the packet on the wire.
  rec_t       q[$];
  logic [7:0] cur[$];
  bit         m_send;
  int         m_drops;
  bit         m_pend;
  bit         m_reset_seen;
  logic [8:0] got[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_packet(input rec_t r);
    cur.delete();
    cur.push_back({1'b1, r.drop, r.mw, r.rw, r.fl});
    for (int k = 3; k >= 0; k--) cur.push_back(r.pc[8*k +: 8]);
    for (int k = 3; k >= 0; k--) cur.push_back(r.ins[8*k +: 8]);
    if (r.mw || r.rw) for (int k = 3; k >= 0; k--) cur.push_back(r.alu[8*k +: 8]);
    if (r.mw)         for (int k = 3; k >= 0; k--) cur.push_back(r.wd[8*k +: 8]);
  endtask

  task automatic model_edge();
    rec_t r;
    bit   popped;
    if (!reset) begin
      q.delete(); cur.delete();
      m_send = 0; m_drops = 0; m_pend = 0; m_reset_seen = 1;
      return;
    end
    m_reset_seen = 0;
    if (m_send && tx_ready) begin
      void'(cur.pop_front());
      if (cur.size() == 0) m_send = 0;
    end
    popped = 0;
    if (!m_send && q.size() > 0) begin
      load_packet(q.pop_front());
      m_send = 1;
      popped = 1;
    end
    if (cap_en) begin
      if (q.size() < DEPTH) begin
        r.mw = mem_write_in; r.rw = reg_write_in; r.fl = flags_in; r.drop = m_pend;
        r.pc = pc_in; r.ins = instr_in; r.alu = alu_result_in; r.wd = write_data_in;
        q.push_back(r);
        m_pend = 0;
      end else begin
        if (m_drops < 255) m_drops++;
        m_pend = 1;
      end
    end
  endtask

  task automatic cycle();
    if (reset && tx_valid && tx_ready) got.push_back({tx_last, tx_data});
    @(posedge clk);
    model_edge();
    #1;
    chk("tx_valid", tx_valid, m_send);
    chk("busy", busy, m_send);
    chk("fifo_level", fifo_level, q.size());
    chk("drop_count", drop_count, m_drops);
    if (m_send) begin
      chk("tx_data", tx_data, cur[0]);
      chk("tx_last", tx_last, cur.size() == 1);
    end else if (m_reset_seen) begin
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_last", tx_last, 0);
    end
  endtask

  task automatic set_rec(input logic mw, input logic rw, input logic [3:0] fl,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [31:0] wd);
    mem_write_in = mw; reg_write_in = rw; flags_in = fl;
    pc_in = pc; instr_in = ins; alu_result_in = alu; write_data_in = wd;
  endtask

  task automatic rand_rec();
    set_rec(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic run(input int n, input logic cap, input logic rdy);
    for (int i = 0; i < n; i++) begin
      cap_en = cap; tx_ready = rdy;
      if (cap) rand_rec();
      cycle();
    end
  endtask

  logic [7:0] exp_plain[9];
  int         hdr_cnt;
  bit         after_last;
  bit         waited;

  initial begin
    exp_plain = '{8'h84, 8'h00, 8'h00, 8'h00, 8'h08, 8'hE2, 8'h80, 8'h20, 8'h05};
    reset = 1'b0; cap_en = 1'b0; tx_ready = 1'b0;
    set_rec(0, 0, 0, 0, 0, 0, 0);
    run(3, 0, 0);
    reset = 1'b1;
    run(2, 0, 1);

    // Plain 9-byte record
    got.delete();
    cap_en = 1; tx_ready = 1;
    set_rec(0, 0, 4'b0100, 32'h8, 32'hE280_2005, 32'h1234_5678, 32'h9ABC_DEF0);
    cycle();
    run(12, 0, 1);
    chk("plain_len", got.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk("plain_byte", got[i][7:0], exp_plain[i]);
      chk("plain_last", got[i][8], i == 8);
    end

    // Store then register-write record
    got.delete();
    cap_en = 1; tx_ready = 1;
    set_rec(1, 0, 4'b0000, 32'h10, 32'hE580_1000, 32'h64, 32'h7);
    cycle();
    set_rec(0, 1, 4'b0011, 32'h14, 32'hE281_100C, 32'hC, 32'hDEAD_BEEF);
    cycle();
    run(35, 0, 1);
    chk("st_len", got.size(), 30);
    chk("st_hdr", got[0][7:0], 8'hA0);
    chk("st_alu_lsb", got[12][7:0], 8'h64);
    chk("st_wd_lsb", got[16], {1'b1, 8'h07});
    chk("rw_hdr", got[17][7:0], 8'h93);
    chk("rw_end", got[29], {1'b1, 8'h0C});

    // Backpressure at byte 6
    got.delete();
    cap_en = 1; tx_ready = 1;
    set_rec(1, 1, 4'b1010, $urandom, $urandom, $urandom, $urandom);
    cycle();
    run(6, 0, 1);
    run(5, 0, 0);
    run(20, 0, 1);
    chk("bp_len", got.size(), 17);

    // Overflow with drop flag on the next accepted record
    got.delete();
    run(12, 1, 0);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_drops", drop_count, 3);
    chk("ovf_busy", busy, 1);
    waited = 0;
    for (int i = 0; i < 60 && !waited; i++) begin
      run(1, 0, 1);
      if (fifo_level == 7) waited = 1;
    end
    chk("ovf_wait_level7", waited, 1);
    run(1, 1, 1);
    run(200, 0, 1);
    hdr_cnt = 0; after_last = 1;
    for (int i = 0; i < got.size(); i++) begin
      if (after_last) begin
        hdr_cnt++;
        chk("ovf_hdr_drop", got[i][6], hdr_cnt == 10);
      end
      after_last = got[i][8];
    end
    chk("ovf_pkts", hdr_cnt, 10);

    // Saturation, then back-to-back packets
    run(320, 1, 0);
    chk("sat_drops", drop_count, 8'hFF);
    run(200, 0, 1);
    got.delete();
    cap_en = 1; tx_ready = 1;
    set_rec(0, 0, 4'($urandom), $urandom, $urandom, $urandom, $urandom);
    cycle();
    set_rec(0, 0, 4'($urandom), $urandom, $urandom, $urandom, $urandom);
    cycle();
    run(25, 0, 1);
    chk("b2b_len", got.size(), 18);
    for (int i = 0; i < got.size(); i++) chk("b2b_last", got[i][8], (i == 8) || (i == 17));

    // Reset mid-packet with three records queued
    run(4, 1, 0);
    run(4, 0, 1);
    reset = 1'b0;
    run(1, 0, 1);
    chk("rst_valid", tx_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drops", drop_count, 0);
    reset = 1'b1;
    got.delete();
    run(20, 0, 1);
    chk("rst_stale", got.size(), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cap_en   = ($urandom_range(0, 99) < 35);
      tx_ready = ($urandom_range(0, 99) < 70);
      rand_rec();
      cycle();
    end
    run(400, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_packetizer.md
# trace_packetizer

Hardware commit-trace unit for the single-cycle ARM core. Each cycle it captures the core's debug observation signals (PC, instruction, write results, NZCV flags) into a small FIFO. It then serializes each record as a variable-length byte packet on a valid/ready stream toward a UART or a debug host. It is the on-chip producer of the per-cycle log the simulation environment prints, so the same trace is available on silicon.

## Interface
- DEPTH, 8, FIFO record depth; must be a power of 2 and at least 2.
- AW, 3, log2(DEPTH).

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low.
- cap_en  input  1  capture the current cycle's record; tied to core-not-in-reset.
- pc_in  input  32  PC of the executing instruction.
- instr_in  input  32  instruction word.
- alu_result_in  input  32  ALU result; this is the store address when mem_write_in=1.
- write_data_in  input  32  store data.
- mem_write_in  input  1  instruction writes memory.
- reg_write_in  input  1  instruction writes the register file.
- flags_in  input  4  {N,Z,C,V}.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  consumer accepts the byte.
- tx_last  output  1  current byte is the final byte of its packet.
- drop_count  output  8  records lost to a full FIFO; saturates at 255.
- fifo_level  output  AW+1  records currently queued, excluding the record being serialized.
- busy  output  1  serializer is in SEND.

## Operation
- Record contents: {mw, rw, flags, pc, instr, alu_result, write_data}, latched at the rising edge when cap_en=1.
- Push rule:
  - A push is accepted if fifo_level<DEPTH, or if the FIFO is full and the serializer pops in the same cycle.
  - Otherwise the record is dropped: drop_count increments (saturating at 255) and a sticky drop_pending flag is set.
- drop_pending is stored as the drop bit of the next accepted record and clears on that push. If a drop and an accept can never coincide in one cycle, no special case is needed.
- Packet format, big-endian (MSB first):
  - Header byte = {1, drop, mw, rw, N, Z, C, V}.
  - Then PC (4 bytes), then instr (4 bytes).
  - If mw=1: alu_result (4) then write_data (4); packet length 17.
  - Else if rw=1: alu_result (4); packet length 13.
  - Otherwise packet length 9.
  - mw=rw=1 is encoded as mw (17 bytes) with both header bits set.
- Serializer FSM states:
  - IDLE: if fifo_level>0, pop the head into the shift record, set idx=0, go to SEND.
  - SEND: tx_valid=1, tx_data=byte[idx], tx_last=(idx==len-1).
    - On tx_valid & tx_ready with tx_last=0: idx++.
    - On tx_valid & tx_ready with tx_last=1: if the FIFO is non-empty, pop the next record, set idx=0 and stay in SEND. Otherwise go to IDLE.
- While tx_valid=1 and tx_ready=0, tx_data, tx_last and idx hold.
- FIFO pointers are AW bits wide and wrap modulo DEPTH. fifo_level equals push count minus pop count.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, tx_last=0, drop_count=0, fifo_level=0, busy=0. FIFO pointers=0, drop_pending=0, state=IDLE.
- Reset during a packet aborts the packet. Queued records are discarded and nothing resumes after reset.
- Latency: a record captured at edge E is popped at E+1, and its header is presented from E+1 until accepted. This gives 1 cycle of FIFO residency.
- Throughput: 1 byte per cycle when tx_ready=1.
- Back-to-back packets have zero bubble between the last byte of one and the header of the next.
- A sustained capture rate of 1 record per cycle always overflows. Drops are expected and counted; they are not an error.
- Same-cycle push and pop: fifo_level is unchanged.

## Test plan
- Plain record: cap_en pulse with pc=0x00000008, instr=0xE2802005, mw=rw=0, flags=0100, tx_ready=1 -> bytes 84 00 00 00 08 E2 80 20 05; tx_last only on the 9th byte; busy falls the next cycle.
- Store and register write:
  - mw=1, alu=0x00000064, wd=0x00000007, flags=0000 -> 17 bytes, header 0xA0, ending 00 00 00 64 00 00 00 07.
  - Next record rw=1, alu=0x0000000C -> 13 bytes, header 0x90|flags.
- Backpressure: drop tx_ready for 5 cycles at byte 6 of a packet -> tx_data and tx_last are stable throughout; no byte is skipped or duplicated; total packet length is unchanged.
- Overflow: DEPTH=8, tx_ready=0, cap_en high for 12 edges -> fifo_level=8, drop_count=3, busy=1. Then raise tx_ready, let fifo_level fall to 7, and capture one record -> that record's header has bit6=1, and earlier headers have bit6=0.
- Saturation and back-to-back: force more than 300 drops -> drop_count holds at 0xFF. Queue two 9-byte records with tx_ready=1 -> 18 consecutive valid cycles, with tx_last at cycles 9 and 18.
- Reset mid-packet: assert reset at byte 4 with 3 records queued -> on the next edge tx_valid=0, fifo_level=0, drop_count=0; after release, no stale bytes appear until a new capture.
